// File: rtl/pulse_filter_pkg.sv
// Shared definitions for the pulse-width filter: FSM state encodings and
// default parameter values.
package pulse_filter_pkg;

  localparam int unsigned DEF_MIN_WIDTH = 4;
  localparam int unsigned DEF_CNT_W     = 8;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_LO   = 2'd0;
  localparam logic [STATE_W-1:0] PEND_HI = 2'd1;
  localparam logic [STATE_W-1:0] ST_HI   = 2'd2;
  localparam logic [STATE_W-1:0] PEND_LO = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous inputs.
// It resets asynchronously to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pulse_width_filter.sv
// Pulse-width filter: passes a level change on din only after MIN_WIDTH
// consecutive identical synchronized samples. It rejects and counts shorter pulses.
module pulse_width_filter
  import pulse_filter_pkg::*;
#(
  parameter int unsigned MIN_WIDTH = DEF_MIN_WIDTH,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             glitch,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int unsigned CW = $clog2(MIN_WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(MIN_WIDTH - 1);
  localparam logic [CNT_W-1:0] GCNT_MAX = {CNT_W{1'b1}};

  logic din_s;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dout_q, dout_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               glitch_q, glitch_d;
  logic [CNT_W-1:0]   glitch_cnt_q, glitch_cnt_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );

  // Next-state, sample counter, strobes and glitch counter
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    glitch_d     = 1'b0;
    glitch_cnt_d = glitch_cnt_q;

    case (state_q)
      ST_LO: begin
        if (din_s) begin
          state_d = PEND_HI;
          cnt_d   = CW'(1);
        end
      end
      PEND_HI: begin
        if (din_s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_HI;
            cnt_d   = '0;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d  = ST_LO;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end
      end
      ST_HI: begin
        if (!din_s) begin
          state_d = PEND_LO;
          cnt_d   = CW'(1);
        end
      end
      PEND_LO: begin
        if (!din_s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_LO;
            cnt_d   = '0;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d  = ST_HI;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase

    // Clear takes priority over a same-cycle glitch; count saturates
    if (clr_cnt) begin
      glitch_cnt_d = '0;
    end else if (glitch_d && (glitch_cnt_q != GCNT_MAX)) begin
      glitch_cnt_d = glitch_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LO;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      glitch_q     <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      glitch_q     <= glitch_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch     = glitch_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_pulse_width_filter.sv
// Directed self-checking bench for pulse_width_filter (MIN_WIDTH=4, CNT_W=2,
// 10 ns clock).
module tb_pulse_width_filter;

  localparam int unsigned MIN_WIDTH = 4;
  localparam int unsigned CNT_W     = 2;

  logic             clk;
  logic             rst;
  logic             din;
  logic             clr_cnt;
  logic             dout;
  logic             rise;
  logic             fall;
  logic             glitch;
  logic [CNT_W-1:0] glitch_cnt;

  int n_tests;
  int n_fail;
  int n_rise;
  int n_fall;
  int n_glitch;
  int n_multi;
  int s_rise;
  int s_fall;
  int s_glitch;

  pulse_width_filter #(
    .MIN_WIDTH (MIN_WIDTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .clr_cnt    (clr_cnt),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .glitch     (glitch),
    .glitch_cnt (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; sample 1 ns after each edge and tally strobes
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      n_rise   += int'(rise);
      n_fall   += int'(fall);
      n_glitch += int'(glitch);
      if ((int'(rise) + int'(fall) + int'(glitch)) > 1) n_multi++;
    end
  endtask

  task automatic snap();
    s_rise   = n_rise;
    s_fall   = n_fall;
    s_glitch = n_glitch;
  endtask

  // din high for 3 capture edges, then low; glitch lands 3 edges later
  task automatic short_high_pulse();
    din = 1'b1;
    step(3);
    din = 1'b0;
    step(2);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    n_rise = 0; n_fall = 0; n_glitch = 0; n_multi = 0;
    rst = 1'b1; din = 1'b1; clr_cnt = 1'b0;

    // Reset with din high
    step(2);
    check("rst_dout", int'(dout), 0);
    check("rst_rise", int'(rise), 0);
    check("rst_fall", int'(fall), 0);
    check("rst_glitch", int'(glitch), 0);
    check("rst_gcnt", int'(glitch_cnt), 0);
    snap();
    rst = 1'b0;
    step(5);
    check("rst_rel_e5_dout", int'(dout), 0);
    step(1);
    check("rst_rel_e6_dout", int'(dout), 1);
    check("rst_rel_e6_rise", int'(rise), 1);
    step(1);
    check("rst_rel_rise_cnt", n_rise - s_rise, 1);

    // Fall after holding low for 4 capture edges
    din = 1'b0;
    step(5);
    check("fall_e5_dout", int'(dout), 1);
    step(1);
    check("fall_e6_dout", int'(dout), 0);
    check("fall_e6_fall", int'(fall), 1);
    step(3);

    // Short high pulse (3 edges) rejected
    snap();
    short_high_pulse();
    check("short_pre_glitch", int'(glitch), 0);
    step(1);
    check("short_glitch", int'(glitch), 1);
    check("short_gcnt", int'(glitch_cnt), 1);
    check("short_dout", int'(dout), 0);
    step(3);
    check("short_rise_cnt", n_rise - s_rise, 0);
    check("short_glitch_cnt", n_glitch - s_glitch, 1);

    // Exact width: 4 capture edges high, then 4 low
    snap();
    din = 1'b1;
    step(4);
    din = 1'b0;
    step(1);
    check("exact_e5_dout", int'(dout), 0);
    step(1);
    check("exact_e6_dout", int'(dout), 1);
    check("exact_e6_rise", int'(rise), 1);
    step(3);
    check("exact_lo_e5_dout", int'(dout), 1);
    step(1);
    check("exact_lo_e6_dout", int'(dout), 0);
    check("exact_lo_e6_fall", int'(fall), 1);
    step(3);
    check("exact_glitch_cnt", n_glitch - s_glitch, 0);

    // Short low pulse while high is rejected, dout stays high
    din = 1'b1;
    step(8);
    check("hi_settle_dout", int'(dout), 1);
    snap();
    din = 1'b0;
    step(3);
    din = 1'b1;
    step(2);
    step(1);
    check("lo_short_glitch", int'(glitch), 1);
    check("lo_short_gcnt", int'(glitch_cnt), 2);
    step(4);
    check("lo_short_dout", int'(dout), 1);
    check("lo_short_fall_cnt", n_fall - s_fall, 0);
    din = 1'b0;
    step(8);
    check("lo_settle_dout", int'(dout), 0);

    // Sub-period glitch between clock edges is invisible
    snap();
    #2 din = 1'b1;
    #2 din = 1'b0;
    step(8);
    check("subp_rise_cnt", n_rise - s_rise, 0);
    check("subp_glitch_cnt", n_glitch - s_glitch, 0);
    check("subp_gcnt", int'(glitch_cnt), 2);
    check("subp_dout", int'(dout), 0);

    // Saturation at 3 with CNT_W=2
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    check("sat_clr_gcnt", int'(glitch_cnt), 0);
    snap();
    for (int k = 0; k < 5; k++) begin
      short_high_pulse();
      step(1);
      check($sformatf("sat_glitch_%0d", k), int'(glitch), 1);
      check($sformatf("sat_gcnt_%0d", k), int'(glitch_cnt), (k < 3) ? k + 1 : 3);
      step(2);
    end
    check("sat_glitch_total", n_glitch - s_glitch, 5);

    // Clear colliding with a glitch: clear wins, strobe still fires
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      short_high_pulse();
      step(3);
    end
    check("coll_pre_gcnt", int'(glitch_cnt), 2);
    short_high_pulse();
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    check("coll_glitch", int'(glitch), 1);
    check("coll_gcnt", int'(glitch_cnt), 0);
    step(3);

    // Reset during PEND_HI discards the pending change
    snap();
    din = 1'b1;
    step(4);
    rst = 1'b1;
    #1;
    check("rst_pend_dout", int'(dout), 0);
    step(2);
    din = 1'b0;
    rst = 1'b0;
    step(8);
    check("rst_pend_rise_cnt", n_rise - s_rise, 0);
    check("rst_pend_glitch_cnt", n_glitch - s_glitch, 0);
    check("rst_pend_dout_after", int'(dout), 0);

    check("one_hot_strobes", n_multi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
